cache_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single physical-memory port between the instruction cache and the data cache of the pipelined RV32I core. It accepts line-sized miss/writeback requests from both caches, grants one at a time, and drives the downstream memory or L2 port. It returns read data and a one-cycle response to the granted cache only. Simultaneous requests alternate between the two caches so neither starves.

---
 rtl/cache_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-wide memory port between the I-cache
// and the D-cache. One transaction is in flight at a time; ties alternate
// between the caches. A one-cycle RELEASE state follows every completion so
// that a request still held high after its resp pulse cannot be regranted.
module cache_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // I-cache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // D-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // memory port
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t              state_r,      state_nx_s;
    grant_t              last_grant_r, last_grant_nx_s;
    logic                m_read_r,     m_read_nx_s;
    logic                m_write_r,    m_write_nx_s;
    logic [ADDR_W-1:0]   m_addr_r,     m_addr_nx_s;
    logic [LINE_W-1:0]   m_wdata_r,    m_wdata_nx_s;

    logic                d_req_s;
    logic                any_req_s;
    logic                pick_d_s;

    assign d_req_s   = d_read | d_write;
    assign any_req_s = i_read | d_req_s;

    // Winner selection in IDLE: a lone requester wins, a tie goes to the
    // cache that was not granted last time.
    always_comb begin
        pick_d_s = 1'b0;
        if (i_read && d_req_s) begin
            pick_d_s = (last_grant_r == GRANT_I);
        end else begin
            pick_d_s = d_req_s;
        end
    end

    // Next-state and next memory-port register values.
    always_comb begin
        state_nx_s      = state_r;
        last_grant_nx_s = last_grant_r;
        m_read_nx_s     = m_read_r;
        m_write_nx_s    = m_write_r;
        m_addr_nx_s     = m_addr_r;
        m_wdata_nx_s    = m_wdata_r;
        case (state_r)
            IDLE: begin
                if (any_req_s && pick_d_s) begin
                    // d_read together with d_write is resolved as a write.
                    state_nx_s      = SERVE_D;
                    last_grant_nx_s = GRANT_D;
                    m_write_nx_s    = d_write;
                    m_read_nx_s     = ~d_write;
                    m_addr_nx_s     = d_addr;
                    m_wdata_nx_s    = d_wdata;
                end else if (any_req_s) begin
                    state_nx_s      = SERVE_I;
                    last_grant_nx_s = GRANT_I;
                    m_read_nx_s     = 1'b1;
                    m_write_nx_s    = 1'b0;
                    m_addr_nx_s     = i_addr;
                    m_wdata_nx_s    = {LINE_W{1'b0}};
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (m_resp) begin
                    state_nx_s   = RELEASE;
                    m_read_nx_s  = 1'b0;
                    m_write_nx_s = 1'b0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            RELEASE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s   = IDLE;
                m_read_nx_s  = 1'b0;
                m_write_nx_s = 1'b0;
            end
        endcase
    end

    // State, grant history and latched memory-port request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_I;
            m_read_r     <= 1'b0;
            m_write_r    <= 1'b0;
            m_addr_r     <= {ADDR_W{1'b0}};
            m_wdata_r    <= {LINE_W{1'b0}};
        end else begin
            state_r      <= state_nx_s;
            last_grant_r <= last_grant_nx_s;
            m_read_r     <= m_read_nx_s;
            m_write_r    <= m_write_nx_s;
            m_addr_r     <= m_addr_nx_s;
            m_wdata_r    <= m_wdata_nx_s;
        end
    end

    assign m_read  = m_read_r;
    assign m_write = m_write_r;
    assign m_addr  = m_addr_r;
    assign m_wdata = m_wdata_r;

    // Read data is broadcast; only the resp pulse of the granted cache
    // qualifies it, and it follows m_resp with no added latency.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign i_resp  = (state_r == SERVE_I) && m_resp;
    assign d_resp  = (state_r == SERVE_D) && m_resp;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: a cycle table, hand-written corner
// sequences, and a randomized run against a transaction-level model.
module tb_cache_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, m_resp;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, m_rdata;
    logic [LW-1:0] i_rdata, d_rdata, m_wdata;
    logic          i_resp, d_resp, m_read, m_write;
    logic [AW-1:0] m_addr;

    int n_vec = 0;
    int n_err = 0;

    cache_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_resp(m_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          ir, dr, dw, mr;
        logic          e_mr, e_mw;
        logic [AW-1:0] e_addr;
        logic          e_ir, e_dr;
    } vec_t;

    vec_t tbl [17];

    // random-phase model and stimulus state
    int            cyc, free_at, i_drop, d_drop, lat;
    bit            busy, own_d, last_d, e_w, i_act, d_act, cnt_on, e_i, e_d;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd;
    int            pulses;

    initial begin
        // I addr 0x60, D addr 0x100 throughout the table
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,32'h0,   1'b0,1'b0}; // spurious resp in IDLE
        tbl[1]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,32'h0,   1'b0,1'b0}; // tie after reset
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,32'h100, 1'b0,1'b0}; // D granted first
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,32'h100, 1'b0,1'b1};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,32'h0,   1'b0,1'b0}; // RELEASE, both held
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,   1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,32'h60,  1'b0,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h60,  1'b1,1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,32'h0,   1'b0,1'b0}; // RELEASE ignores both
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,32'h0,   1'b0,1'b0}; // tie, last was I
        tbl[10] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h100, 1'b0,1'b1};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,   1'b0,1'b0};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,   1'b0,1'b0}; // held I regranted in IDLE
        tbl[13] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h60,  1'b1,1'b0};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,   1'b0,1'b0};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,32'h0,   1'b0,1'b0}; // spurious resp in IDLE
        tbl[16] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,   1'b0,1'b0};

        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; m_resp = 1'b0;
        i_addr = 32'h60; d_addr = 32'h100; d_wdata = {16{16'h1234}};
        m_rdata = {8{32'hC0DE_0001}};
        repeat (2) tick();
        chk("rst_m_read",  LW'(m_read),  LW'(1'b0));
        chk("rst_m_write", LW'(m_write), LW'(1'b0));
        chk("rst_m_addr",  LW'(m_addr),  LW'(32'h0));
        chk("rst_m_wdata", m_wdata,      {LW{1'b0}});
        chk("rst_i_resp",  LW'(i_resp),  LW'(1'b0));
        chk("rst_d_resp",  LW'(d_resp),  LW'(1'b0));
        rst = 1'b0;

        // ---------------- table-driven cycle vectors ----------------
        for (int k = 0; k < 17; k++) begin
            tick();
            i_read = tbl[k].ir; d_read = tbl[k].dr; d_write = tbl[k].dw; m_resp = tbl[k].mr;
            chk($sformatf("tbl%0d_m_read", k),  LW'(m_read),  LW'(tbl[k].e_mr));
            chk($sformatf("tbl%0d_m_write", k), LW'(m_write), LW'(tbl[k].e_mw));
            if (tbl[k].e_mr || tbl[k].e_mw)
                chk($sformatf("tbl%0d_m_addr", k), LW'(m_addr), LW'(tbl[k].e_addr));
            #1;
            chk($sformatf("tbl%0d_i_resp", k), LW'(i_resp), LW'(tbl[k].e_ir));
            chk($sformatf("tbl%0d_d_resp", k), LW'(d_resp), LW'(tbl[k].e_dr));
            if (tbl[k].e_ir) chk($sformatf("tbl%0d_i_rdata", k), i_rdata, {8{32'hC0DE_0001}});
            if (tbl[k].e_dr) chk($sformatf("tbl%0d_d_rdata", k), d_rdata, {8{32'hC0DE_0001}});
        end
        m_resp = 1'b0;

        // ---------------- single I read, 4-cycle memory ----------------
        m_rdata = {32{8'hA5}};
        pulses = 0;
        tick();
        i_read = 1'b1; i_addr = 32'h0000_0060;
        for (int k = 1; k <= 6; k++) begin
            tick();
            m_resp = (k == 4);
            if (k == 5) i_read = 1'b0;
            chk("iread_m_read", LW'(m_read), LW'(k <= 4));
            if (k <= 4) chk("iread_m_addr", LW'(m_addr), LW'(32'h60));
            #1;
            if (i_resp) pulses++;
            chk("iread_d_resp", LW'(d_resp), LW'(1'b0));
            if (k == 4) chk("iread_rdata", i_rdata, {32{8'hA5}});
        end
        chk("iread_resp_pulses", LW'(pulses), LW'(1));
        m_resp = 1'b0;

        // ---------------- D writeback ----------------
        pulses = 0;
        tick();
        d_write = 1'b1; d_addr = 32'h100; d_wdata = {16{16'h1234}};
        for (int k = 1; k <= 5; k++) begin
            tick();
            m_resp = (k == 3);
            if (k == 4) d_write = 1'b0;
            d_wdata = (k >= 2) ? {LW{1'b1}} : {16{16'h1234}}; // live data must not leak
            chk("dwb_m_write", LW'(m_write), LW'(k <= 3));
            chk("dwb_m_read",  LW'(m_read),  LW'(1'b0));
            if (k <= 3) begin
                chk("dwb_m_addr",  LW'(m_addr), LW'(32'h100));
                chk("dwb_m_wdata", m_wdata,     {16{16'h1234}});
            end
            #1;
            if (d_resp) pulses++;
            chk("dwb_i_resp", LW'(i_resp), LW'(1'b0));
        end
        chk("dwb_resp_pulses", LW'(pulses), LW'(1));
        m_resp = 1'b0;

        // ---------------- reset mid-transaction ----------------
        tick();
        d_write = 1'b1; d_addr = 32'h200;
        tick();
        chk("rmid_m_write_before", LW'(m_write), LW'(1'b1));
        tick();
        m_resp = 1'b1;
        i_read = 1'b1; i_addr = 32'h60;
        #1;
        rst = 1'b1;
        #1;
        chk("rmid_m_write_async", LW'(m_write), LW'(1'b0));
        chk("rmid_m_read_async",  LW'(m_read),  LW'(1'b0));
        chk("rmid_d_resp_async",  LW'(d_resp),  LW'(1'b0));
        m_resp = 1'b0;
        tick();
        rst = 1'b0;                 // cycle R: tie i_read / d_write in IDLE
        tick();
        chk("rmid_tie_m_write", LW'(m_write), LW'(1'b1));
        chk("rmid_tie_m_addr",  LW'(m_addr),  LW'(32'h200));
        m_resp = 1'b1;
        #1;
        chk("rmid_tie_d_resp", LW'(d_resp), LW'(1'b1));
        tick();
        m_resp = 1'b0; d_write = 1'b0;
        tick();                     // IDLE, only I requesting
        tick();
        chk("rmid_i_m_read", LW'(m_read), LW'(1'b1));
        chk("rmid_i_m_addr", LW'(m_addr), LW'(32'h60));
        m_resp = 1'b1;
        #1;
        chk("rmid_i_resp", LW'(i_resp), LW'(1'b1));
        tick();
        m_resp = 1'b0; i_read = 1'b0;

        // ---------------- randomized run against a transaction model ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy = 1'b0; last_d = 1'b0; free_at = 0; cyc = 0;
        i_act = 1'b0; d_act = 1'b0; cnt_on = 1'b0; lat = 0;
        i_drop = -1; d_drop = -1;
        for (int n = 0; n < 4000; n++) begin
            tick();
            cyc++;
            chk("rnd_m_read",  LW'(m_read),  LW'(busy && !e_w));
            chk("rnd_m_write", LW'(m_write), LW'(busy && e_w));
            if (busy) begin
                chk("rnd_m_addr",  LW'(m_addr), LW'(e_addr));
                chk("rnd_m_wdata", m_wdata,     e_wd);
            end
            // requesters
            if (i_act && cyc == i_drop) begin
                i_act = 1'b0; i_read = 1'b0;
            end else if (!i_act && $urandom_range(0, 3) == 0) begin
                i_act = 1'b1; i_read = 1'b1; i_drop = -1;
                i_addr = $urandom & 32'hFFFF_FFE0;
            end
            if (d_act && cyc == d_drop) begin
                d_act = 1'b0; d_read = 1'b0; d_write = 1'b0;
            end else if (!d_act && $urandom_range(0, 3) == 0) begin
                d_act = 1'b1; d_drop = -1;
                d_addr  = $urandom & 32'hFFFF_FFE0;
                d_wdata = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
                case ($urandom_range(0, 4))
                    0, 1:    begin d_read = 1'b1; d_write = 1'b0; end
                    2, 3:    begin d_read = 1'b0; d_write = 1'b1; end
                    default: begin d_read = 1'b1; d_write = 1'b1; end
                endcase
            end
            // memory
            m_rdata = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
            if (m_read || m_write) begin
                if (!cnt_on) begin cnt_on = 1'b1; lat = $urandom_range(0, 4); end
                if (lat == 0) begin m_resp = 1'b1; cnt_on = 1'b0; end
                else begin m_resp = 1'b0; lat--; end
            end else begin
                cnt_on = 1'b0;
                m_resp = ($urandom_range(0, 15) == 0);
            end
            #1;
            e_i = busy && !own_d && m_resp;
            e_d = busy && own_d && m_resp;
            chk("rnd_i_resp", LW'(i_resp), LW'(e_i));
            chk("rnd_d_resp", LW'(d_resp), LW'(e_d));
            if (e_i) begin
                chk("rnd_i_rdata", i_rdata, m_rdata);
                i_drop = cyc + 1 + int'($urandom_range(0, 1));
            end
            if (e_d) begin
                chk("rnd_d_rdata", d_rdata, m_rdata);
                d_drop = cyc + 1 + int'($urandom_range(0, 1));
            end
            // model: one transaction at a time, free two cycles after completion
            if (busy) begin
                if (m_resp) begin busy = 1'b0; free_at = cyc + 2; end
            end else if (cyc >= free_at && (i_read || d_read || d_write)) begin
                own_d  = (i_read && (d_read || d_write)) ? !last_d : (d_read || d_write);
                last_d = own_d;
                busy   = 1'b1;
                if (own_d) begin
                    e_addr = d_addr; e_w = d_write; e_wd = d_wdata;
                end else begin
                    e_addr = i_addr; e_w = 1'b0; e_wd = {LW{1'b0}};
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
